// File: rtl/trigger_unit.sv
// -----------------------------------------------------------------------------
// trigger_unit
//
// Trigger controller for the capture path. Combines NUM_CH channel triggers
// and one protocol trigger under a per-source enable mask (AND or OR mode).
// The combined condition must be qualified over qual_len consecutive sample
// strobes before it fires. After firing, the block counts post_cnt sample
// strobes, then flags capture complete and holds until acknowledged.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   ch_trig      per-channel trigger condition (bit i = channel i+1)
//   prot_trig    protocol-decoder trigger condition
//   ch_en        per-channel enable mask          (latched on arm)
//   prot_en      protocol trigger enable          (latched on arm)
//   trig_mode    0 = AND of enabled, 1 = OR       (latched on arm)
//   qual_len     qualifying strobes, 0 means 1    (latched on arm)
//   post_cnt     post-trigger strobes to capture  (latched on arm)
//   armed        level arm request
//   force_trig   software trigger, bypasses source logic and qualification
//   smpl_en      sample strobe; all counting happens only on strobes
//   capture_ack  returns the block to IDLE, highest priority in every state
//   triggered    sticky trigger flag (registered)
//   trig_pulse   one-cycle pulse on entry to TRIG (registered)
//   capture_done high while in DONE (registered)
//   state        raw FSM encoding: IDLE=0, WAIT=1, TRIG=2, DONE=3
//
// Interface: level based, no valid/ready handshake. capture_done stays high
// until capture_ack is seen on a rising edge; if armed is still high then,
// the block passes through IDLE for one cycle and re-arms automatically.
// -----------------------------------------------------------------------------
module trigger_unit #(
  parameter int NUM_CH = 5,
  parameter int QUAL_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_trig,
  input  logic              prot_trig,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              prot_en,
  input  logic              trig_mode,
  input  logic [QUAL_W-1:0] qual_len,
  input  logic [CNT_W-1:0]  post_cnt,
  input  logic              armed,
  input  logic              force_trig,
  input  logic              smpl_en,
  input  logic              capture_ack,
  output logic              triggered,
  output logic              trig_pulse,
  output logic              capture_done,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_TRIG = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [QUAL_W:0]   ONE_QW = 1;
  localparam logic [QUAL_W-1:0] ONE_Q  = 1;
  localparam logic [CNT_W-1:0]  ONE_C  = 1;

  state_t              r_state;
  logic                r_triggered;
  logic                r_trig_pulse;
  logic                r_done;
  logic [QUAL_W-1:0]   r_qual_cnt;
  logic [CNT_W-1:0]    r_post_cnt;

  // Configuration captured on the IDLE->WAIT edge
  logic [NUM_CH-1:0]   r_ch_en;
  logic                r_prot_en;
  logic                r_mode;
  logic [QUAL_W-1:0]   r_qual_len;
  logic [CNT_W-1:0]    r_post_len;

  logic                w_any_en;
  logic                w_and_ok;
  logic                w_or_hit;
  logic                w_cond;
  logic [QUAL_W:0]     w_qual_next;
  logic [QUAL_W:0]     w_qual_req;
  logic                w_qual_met;
  logic                w_fire;
  logic [CNT_W-1:0]    w_post_next;

  // A disabled source counts as "satisfied" for AND and "silent" for OR;
  // an empty mask never produces a condition in either mode.
  assign w_any_en = (|r_ch_en) | r_prot_en;
  assign w_and_ok = (&(ch_trig | ~r_ch_en)) & (prot_trig | ~r_prot_en);
  assign w_or_hit = (|(ch_trig & r_ch_en)) | (prot_trig & r_prot_en);
  assign w_cond   = w_any_en & (r_mode ? w_or_hit : w_and_ok);

  // One bit wider so the +1 cannot wrap; qual_len of 0 behaves as 1.
  assign w_qual_next = {1'b0, r_qual_cnt} + ONE_QW;
  assign w_qual_req  = (r_qual_len == '0) ? ONE_QW : {1'b0, r_qual_len};
  assign w_qual_met  = (w_qual_next >= w_qual_req);

  assign w_fire      = force_trig | (smpl_en & w_cond & w_qual_met);
  assign w_post_next = r_post_cnt + ONE_C;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_triggered  <= 1'b0;
      r_trig_pulse <= 1'b0;
      r_done       <= 1'b0;
      r_qual_cnt   <= '0;
      r_post_cnt   <= '0;
      r_ch_en      <= '0;
      r_prot_en    <= 1'b0;
      r_mode       <= 1'b0;
      r_qual_len   <= '0;
      r_post_len   <= '0;
    end else begin
      r_trig_pulse <= 1'b0;
      if (capture_ack) begin
        r_state     <= ST_IDLE;
        r_triggered <= 1'b0;
        r_done      <= 1'b0;
        r_qual_cnt  <= '0;
        r_post_cnt  <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (armed) begin
              r_state    <= ST_WAIT;
              r_qual_cnt <= '0;
              r_ch_en    <= ch_en;
              r_prot_en  <= prot_en;
              r_mode     <= trig_mode;
              r_qual_len <= qual_len;
              r_post_len <= post_cnt;
            end
          end
          ST_WAIT: begin
            if (w_fire) begin
              r_state      <= ST_TRIG;
              r_triggered  <= 1'b1;
              r_trig_pulse <= 1'b1;
              r_post_cnt   <= '0;
            end else if (!armed) begin
              r_state <= ST_IDLE;
            end else if (smpl_en) begin
              // Saturate rather than wrap so a long run stays qualified
              if (!w_cond)
                r_qual_cnt <= '0;
              else if (!(&r_qual_cnt))
                r_qual_cnt <= r_qual_cnt + ONE_Q;
            end
          end
          ST_TRIG: begin
            if (r_post_len == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else if (smpl_en) begin
              r_post_cnt <= w_post_next;
              if (w_post_next == r_post_len) begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end
            end
          end
          ST_DONE: begin
            r_done      <= 1'b1;
            r_triggered <= 1'b1;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign triggered    = r_triggered;
  assign trig_pulse   = r_trig_pulse;
  assign capture_done = r_done;
  assign state        = r_state;

endmodule

// File: tb/tb_trigger_unit.sv
module tb_trigger_unit;

  localparam int NUM_CH = 5;
  localparam int QUAL_W = 4;
  localparam int CNT_W  = 16;

  logic              clk;
  logic              rst_n;
  logic [NUM_CH-1:0] ch_trig;
  logic              prot_trig;
  logic [NUM_CH-1:0] ch_en;
  logic              prot_en;
  logic              trig_mode;
  logic [QUAL_W-1:0] qual_len;
  logic [CNT_W-1:0]  post_cnt;
  logic              armed;
  logic              force_trig;
  logic              smpl_en;
  logic              capture_ack;
  logic              triggered;
  logic              trig_pulse;
  logic              capture_done;
  logic [1:0]        state;

  int n_checks = 0;
  int n_errors = 0;

  trigger_unit #(.NUM_CH(NUM_CH), .QUAL_W(QUAL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ch_trig(ch_trig), .prot_trig(prot_trig),
    .ch_en(ch_en), .prot_en(prot_en), .trig_mode(trig_mode),
    .qual_len(qual_len), .post_cnt(post_cnt),
    .armed(armed), .force_trig(force_trig), .smpl_en(smpl_en),
    .capture_ack(capture_ack),
    .triggered(triggered), .trig_pulse(trig_pulse),
    .capture_done(capture_done), .state(state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ch_trig = '0; prot_trig = 0; ch_en = '0; prot_en = 0; trig_mode = 0;
    qual_len = '0; post_cnt = '0; armed = 0; force_trig = 0; smpl_en = 0;
    capture_ack = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  // ---------------- checking ----------------
  task automatic chk_out(input string name, input logic [1:0] es,
                         input logic et, input logic ep, input logic ed);
    logic [4:0] act, exp;
    act = {state, triggered, trig_pulse, capture_done};
    exp = {es, et, ep, ed};
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s state/trig/pulse/done got=%0d/%b/%b/%b want=%0d/%b/%b/%b",
               name, act[4:3], act[2], act[1], act[0], es, et, ep, ed);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic              ack, arm, frc, smpl;
    logic [NUM_CH-1:0] ch;
    logic              pt;
    logic [NUM_CH-1:0] en;
    logic              pen, mode;
    logic [QUAL_W-1:0] ql;
    logic [CNT_W-1:0]  pc;
    logic [1:0]        es;
    logic              et, ep, ed;
  } vec_t;

  vec_t vecs[23];

  task automatic fill_table();
    // AND, all enabled, qual 0, post 3: fire at row 2, done 3 edges later
    vecs[0]  = '{0,1,0,1,5'h00,0,5'h1f,1,0,4'd0,16'd3, 2'd1,0,0,0};
    vecs[1]  = '{0,1,0,1,5'h00,0,5'h1f,1,0,4'd0,16'd3, 2'd1,0,0,0};
    vecs[2]  = '{0,1,0,1,5'h1f,1,5'h1f,1,0,4'd0,16'd3, 2'd2,1,1,0};
    vecs[3]  = '{0,1,0,1,5'h00,0,5'h1f,1,0,4'd0,16'd3, 2'd2,1,0,0};
    vecs[4]  = '{0,1,0,1,5'h00,0,5'h1f,1,0,4'd0,16'd3, 2'd2,1,0,0};
    vecs[5]  = '{0,1,0,1,5'h00,0,5'h1f,1,0,4'd0,16'd3, 2'd3,1,0,1};
    vecs[6]  = '{1,0,0,1,5'h00,0,5'h1f,1,0,4'd0,16'd3, 2'd0,0,0,0};
    // AND, CH1+CH3 only: fires with both high, not with CH3 low
    vecs[7]  = '{0,1,0,1,5'h00,0,5'h05,0,0,4'd0,16'd3, 2'd1,0,0,0};
    vecs[8]  = '{0,1,0,1,5'h05,0,5'h05,0,0,4'd0,16'd3, 2'd2,1,1,0};
    vecs[9]  = '{1,0,0,1,5'h05,0,5'h05,0,0,4'd0,16'd3, 2'd0,0,0,0};
    vecs[10] = '{0,1,0,1,5'h00,0,5'h05,0,0,4'd0,16'd3, 2'd1,0,0,0};
    vecs[11] = '{0,1,0,1,5'h01,0,5'h05,0,0,4'd0,16'd3, 2'd1,0,0,0};
    vecs[12] = '{0,1,0,1,5'h01,1,5'h05,0,0,4'd0,16'd3, 2'd1,0,0,0};
    vecs[13] = '{1,0,0,1,5'h01,1,5'h05,0,0,4'd0,16'd3, 2'd0,0,0,0};
    // Empty mask, AND then OR: never fires; force_trig with post 0
    vecs[14] = '{0,1,0,1,5'h1f,1,5'h00,0,0,4'd0,16'd0, 2'd1,0,0,0};
    vecs[15] = '{0,1,0,1,5'h1f,1,5'h00,0,0,4'd0,16'd0, 2'd1,0,0,0};
    vecs[16] = '{0,1,0,1,5'h1f,1,5'h00,0,0,4'd0,16'd0, 2'd1,0,0,0};
    vecs[17] = '{1,1,0,1,5'h1f,1,5'h00,0,0,4'd0,16'd0, 2'd0,0,0,0};
    vecs[18] = '{0,1,0,1,5'h1f,1,5'h00,0,1,4'd0,16'd0, 2'd1,0,0,0};
    vecs[19] = '{0,1,0,1,5'h1f,1,5'h00,0,1,4'd0,16'd0, 2'd1,0,0,0};
    vecs[20] = '{0,1,1,1,5'h1f,1,5'h00,0,1,4'd0,16'd0, 2'd2,1,1,0};
    vecs[21] = '{0,1,0,1,5'h1f,1,5'h00,0,1,4'd0,16'd0, 2'd3,1,0,1};
    vecs[22] = '{1,0,0,1,5'h1f,1,5'h00,0,1,4'd0,16'd0, 2'd0,0,0,0};
  endtask

  task automatic run_table();
    for (int i = 0; i < 23; i++) begin
      capture_ack = vecs[i].ack; armed = vecs[i].arm; force_trig = vecs[i].frc;
      smpl_en = vecs[i].smpl; ch_trig = vecs[i].ch; prot_trig = vecs[i].pt;
      ch_en = vecs[i].en; prot_en = vecs[i].pen; trig_mode = vecs[i].mode;
      qual_len = vecs[i].ql; post_cnt = vecs[i].pc;
      tick();
      chk_out($sformatf("vec%0d", i), vecs[i].es, vecs[i].et, vecs[i].ep, vecs[i].ed);
    end
    clear_inputs();
  endtask

  // ---------------- reference model ----------------
  // Phase: 0 idle, 1 waiting, 2 capturing, 3 complete
  int                m_phase, m_run, m_posts;
  bit                m_trig, m_pulse, m_done;
  bit [NUM_CH-1:0]   m_ch_en;
  bit                m_prot_en, m_mode;
  int                m_qlen, m_plen;

  task automatic model_reset();
    m_phase = 0; m_run = 0; m_posts = 0;
    m_trig = 0; m_pulse = 0; m_done = 0;
    m_ch_en = '0; m_prot_en = 0; m_mode = 0; m_qlen = 0; m_plen = 0;
  endtask

  function automatic bit model_cond();
    int n_en = 0, n_hi = 0;
    for (int i = 0; i < NUM_CH; i++)
      if (m_ch_en[i]) begin n_en++; if (ch_trig[i]) n_hi++; end
    if (m_prot_en) begin n_en++; if (prot_trig) n_hi++; end
    if (n_en == 0) return 0;
    return m_mode ? (n_hi > 0) : (n_hi == n_en);
  endfunction

  // Advance the model across one rising edge using the current inputs
  task automatic model_step();
    bit c;
    int need;
    c = model_cond();
    m_pulse = 0;
    if (capture_ack) begin
      m_phase = 0; m_trig = 0; m_done = 0; m_run = 0; m_posts = 0;
    end else if (m_phase == 0) begin
      if (armed) begin
        m_phase = 1; m_run = 0;
        m_ch_en = ch_en; m_prot_en = prot_en; m_mode = trig_mode;
        m_qlen = int'(qual_len); m_plen = int'(post_cnt);
      end
    end else if (m_phase == 1) begin
      need = (m_qlen < 1) ? 1 : m_qlen;
      if (force_trig || (smpl_en && c && (m_run + 1 >= need))) begin
        m_phase = 2; m_trig = 1; m_pulse = 1; m_posts = 0;
      end else if (!armed) begin
        m_phase = 0;
      end else if (smpl_en) begin
        m_run = c ? ((m_run + 1 > 15) ? 15 : m_run + 1) : 0;
      end
    end else if (m_phase == 2) begin
      if (m_plen == 0) begin
        m_phase = 3; m_done = 1;
      end else if (smpl_en) begin
        m_posts++;
        if (m_posts == m_plen) begin m_phase = 3; m_done = 1; end
      end
    end
  endtask

  task automatic run_random(input int n);
    model_reset();
    for (int k = 0; k < n; k++) begin
      for (int b = 0; b < NUM_CH; b++) ch_trig[b] = ($urandom_range(0, 3) != 0);
      prot_trig   = ($urandom_range(0, 3) != 0);
      ch_en       = NUM_CH'($urandom);
      prot_en     = 1'($urandom);
      trig_mode   = 1'($urandom);
      qual_len    = QUAL_W'($urandom_range(0, 5));
      post_cnt    = CNT_W'($urandom_range(0, 6));
      armed       = ($urandom_range(0, 9) != 0);
      force_trig  = ($urandom_range(0, 29) == 0);
      smpl_en     = ($urandom_range(0, 2) != 0);
      capture_ack = ($urandom_range(0, 24) == 0);
      model_step();
      tick();
      chk_out($sformatf("rand%0d", k), 2'(m_phase), m_trig, m_pulse, m_done);
    end
    clear_inputs();
  endtask

  // ---------------- directed sequences ----------------
  task automatic seq_qualify();
    do_reset();
    trig_mode = 1; ch_en = '1; prot_en = 1; qual_len = 4'd3; post_cnt = 16'd2;
    armed = 1;
    tick();
    chk_out("qual_arm", 2'd1, 0, 0, 0);
    // Two qualifying strobes, then a break
    ch_trig = 5'h02;
    for (int s = 0; s < 2; s++) begin
      smpl_en = 1; tick(); chk_out("qual_burst1_strobe", 2'd1, 0, 0, 0);
      smpl_en = 0; tick(); chk_out("qual_burst1_gap", 2'd1, 0, 0, 0);
    end
    ch_trig = '0;
    smpl_en = 1; tick(); chk_out("qual_break", 2'd1, 0, 0, 0);
    smpl_en = 0; tick();
    // Three qualifying strobes: fires on the third
    ch_trig = 5'h10;
    for (int s = 0; s < 2; s++) begin
      smpl_en = 1; tick(); chk_out("qual_burst2_strobe", 2'd1, 0, 0, 0);
      smpl_en = 0; tick(); chk_out("qual_burst2_gap", 2'd1, 0, 0, 0);
    end
    smpl_en = 1; tick(); chk_out("qual_fire", 2'd2, 1, 1, 0);
  endtask

  task automatic seq_latch_and_rearm();
    do_reset();
    ch_en = '1; prot_en = 1; post_cnt = 16'd3; armed = 1; smpl_en = 1;
    tick();
    chk_out("latch_arm", 2'd1, 0, 0, 0);
    force_trig = 1; tick(); chk_out("latch_force", 2'd2, 1, 1, 0);
    force_trig = 0; post_cnt = 16'd10;
    tick(); chk_out("latch_post1", 2'd2, 1, 0, 0);
    tick(); chk_out("latch_post2", 2'd2, 1, 0, 0);
    tick(); chk_out("latch_done", 2'd3, 1, 0, 1);
    for (int s = 0; s < 4; s++) begin
      tick(); chk_out("latch_hold", 2'd3, 1, 0, 1);
    end
    capture_ack = 1; tick(); chk_out("rearm_ack", 2'd0, 0, 0, 0);
    capture_ack = 0; tick(); chk_out("rearm_wait", 2'd1, 0, 0, 0);
  endtask

  task automatic seq_collisions();
    do_reset();
    ch_en = '1; prot_en = 1; post_cnt = 16'd3; armed = 1; smpl_en = 1;
    tick();
    ch_trig = '1; prot_trig = 1; capture_ack = 1;
    tick(); chk_out("ack_vs_fire", 2'd0, 0, 0, 0);
    capture_ack = 0;
    tick(); chk_out("ack_rearm", 2'd1, 0, 0, 0);
    tick(); chk_out("ack_then_fire", 2'd2, 1, 1, 0);
    tick(); chk_out("pre_reset_trig", 2'd2, 1, 0, 0);
    // Reset between edges must clear without a clock edge
    #2 rst_n = 0;
    #1 chk_out("async_reset", 2'd0, 0, 0, 0);
    #2 rst_n = 1;
    clear_inputs();
  endtask

  // ---------------- main ----------------
  initial begin
    clear_inputs();
    rst_n = 0;
    #2;
    chk_out("reset_state", 2'd0, 0, 0, 0);
    tick();
    rst_n = 1;
    tick();
    chk_out("reset_idle", 2'd0, 0, 0, 0);

    fill_table();
    run_table();
    seq_qualify();
    seq_latch_and_rearm();
    seq_collisions();

    do_reset();
    run_random(3000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/trigger_unit.md
Name: trigger_unit

Overview:
Parametrised trigger controller for the capture path. It combines NUM_CH channel trigger inputs and one protocol trigger under a per-source enable mask in AND or OR mode. A trigger must be qualified over a programmable number of consecutive sample strobes before it fires. After firing, the block counts a programmable number of post-trigger samples, then flags capture complete and holds until acknowledged. It sits between the channel/protocol trigger detectors and the capture RAM controller.

Parameters:
NUM_CH, 5, number of channel trigger inputs (1..16)
QUAL_W, 4, width of qualification length
CNT_W, 16, width of post-trigger sample count

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
ch_trig  input  NUM_CH  per-channel trigger condition, bit i = channel i+1
prot_trig  input  1  protocol-decoder trigger condition
ch_en  input  NUM_CH  per-channel enable mask
prot_en  input  1  protocol trigger enable
trig_mode  input  1  0 = AND of enabled sources, 1 = OR of enabled sources
qual_len  input  QUAL_W  consecutive qualifying samples required (0 treated as 1)
post_cnt  input  CNT_W  samples to capture after trigger
armed  input  1  level; arm request from capture control
force_trig  input  1  software trigger, bypasses source logic and qualification
smpl_en  input  1  sample strobe; all counting occurs only on smpl_en cycles
capture_ack  input  1  clears the block back to IDLE
triggered  output  1  registered, sticky trigger flag
trig_pulse  output  1  one-cycle pulse on entry to TRIG
capture_done  output  1  registered, high while in DONE
state  output  2  IDLE=0, WAIT=1, TRIG=2, DONE=3

Behaviour:
- Reset: state=IDLE; triggered, trig_pulse and capture_done are 0; internal counters are 0; latched configuration is 0.
- Configuration latch: ch_en, prot_en, trig_mode, qual_len and post_cnt are captured on the IDLE->WAIT edge. Later changes are ignored until the next arm.
- cond is evaluated combinationally from the latched mask:
  - AND mode: every enabled source is high.
  - OR mode: any enabled source is high.
  - No source enabled: cond=0 in both modes.
- IDLE: when armed=1, go to WAIT on the next edge and clear qual_cnt.
- WAIT:
  - On each smpl_en cycle, qual_cnt increments if cond=1 and clears to 0 if cond=0. Non-smpl_en cycles hold qual_cnt.
  - Fire condition: smpl_en & cond & (qual_cnt+1 >= max(qual_len,1)), or force_trig=1 on any cycle.
  - On fire, at the same edge: state=TRIG, triggered=1, trig_pulse=1 for exactly that one cycle, post counter cleared.
  - armed=0 in WAIT with no fire in that cycle: go to IDLE.
- qual_cnt saturates at its maximum value. No wrap-around.
- TRIG:
  - triggered stays 1. armed is ignored.
  - The post counter increments on smpl_en.
  - At the edge where the incremented count equals the latched post_cnt, go to DONE.
  - Latched post_cnt=0: go to DONE on the first cycle in TRIG, regardless of smpl_en.
  - Latency with post_cnt=N: capture_done rises on the edge of the N-th smpl_en strobe after trigger entry.
- DONE: capture_done=1 and triggered=1, held indefinitely until capture_ack.
- capture_ack has the highest priority in every state. On the next edge: state=IDLE, and triggered, capture_done and the counters clear.
  - capture_ack in TRIG aborts the capture.
  - capture_ack coincident with a fire condition in WAIT: ack wins and the block does not trigger.
  - armed still high after ack: the block re-enters WAIT one cycle later, so it re-arms automatically.
- Asynchronous reset mid-operation returns immediately to the reset values, from any state.
- All outputs are registered. state is the raw FSM encoding.

Test Plan:
- NUM_CH=5, AND mode, all enabled, qual_len=0, post_cnt=3, smpl_en=1 constant. Arm, then drive all 6 sources high at cycle t. Required: triggered and trig_pulse at t+1; capture_done at t+4; state reads 1, 2, then 3.
- AND mode, ch_en=5'b00101, prot_en=0. Sources CH1 and CH3 high, others low. Required: trigger fires. Then CH3 low. Required: no trigger.
- OR mode, qual_len=3, smpl_en every other cycle. cond high for 2 strobes then drops, then high for 3 strobes. Required: trigger only after the 3rd consecutive strobe; the first burst does not fire.
- Mask all zero in both modes with all sources high. Required: never triggers. force_trig pulse: triggered on the next edge; post_cnt=0 gives capture_done one cycle later.
- In TRIG, change post_cnt from 3 to 10. Required: completes after 3 strobes. Then assert capture_ack while armed stays high. Required: IDLE, then WAIT the following cycle, with all flags cleared.
- Simultaneous events: capture_ack and fire in the same WAIT cycle gives IDLE with triggered=0. Reset asserted in TRIG gives triggered=0 and state=0 immediately, without waiting for a clock edge.
